dem_tree_recombiner: RTL
========================

Name: dem_tree_recombiner

Overview:
- Receive-side counterpart of the 3-layer DEM switching tree.
- Sums the 8 leaf (unit-element) codes back into one reconstructed value through a 3-stage pipelined adder tree.
- Compares the reconstructed value against the original tree input, delayed to match, and tracks lock/fault status.
- Sits beside the switching tree as a run-time integrity monitor; it never modifies the DAC path.

Parameters:
- IN_W, default INPUT_WIDTH (lib_switchblock_pkg): width of each leaf code and of the reference input, signed.
- REF_DELAY, default 3: cycles of latency of the switching tree from x_ref_i to the leaf outputs.
- LOCK_COUNT, default 4: consecutive matches needed to go from TRACK to LOCKED (≥1).
- CNT_W, default 16: width of the saturating mismatch counter.

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- valid_i  in  1  leaf codes valid this cycle
- x_leaf_i  in  8×IN_W  signed leaf codes; index 0..7 = tree outputs 3_1..3_8
- x_ref_i  in  IN_W  signed value driven into the tree REF_DELAY cycles earlier, sampled every cycle
- clear_i  in  1  sync clear: counter to 0, FSM to IDLE
- x_sum_o  out  IN_W+3  signed reconstructed sum
- valid_o  out  1  x_sum_o / match_o valid
- match_o  out  1  sum equals delayed reference (qualified by valid_o)
- mismatch_o  out  1  single-cycle pulse on a valid mismatch
- mismatch_cnt_o  out  CNT_W  saturating count of mismatches
- state_o  out  2  00 IDLE, 01 TRACK, 10 LOCKED, 11 FAULT

Behaviour:
- Reset (reset_i=0, async): all pipeline registers, the delay line, and every output are 0; state_o=IDLE.
- Adder tree, one register per stage, valid piped alongside:
  - S1: 4 pairwise sums (0+1, 2+3, 4+5, 6+7) at IN_W+1 bits.
  - S2: 2 sums at IN_W+2 bits.
  - S3: total at IN_W+3 bits.
- All additions are sign-extended, so the tree has no internal overflow.
- Latency: x_leaf_i/valid_i to x_sum_o/valid_o is exactly 3 cycles. Throughput is 1 per cycle.
- Reference path: x_ref_i goes through a shift register of REF_DELAY+3 stages, always shifting independent of valid_i. Its output is sign-extended to IN_W+3 and compared with the S3 sum.
- match_o = valid_o & (sum == ref_delayed). mismatch_o = valid_o & ~match. Both are registered together with x_sum_o in S3.
- When valid_o=0: x_sum_o holds its last value, and match_o and mismatch_o are 0.
- mismatch_cnt_o increments by 1 per mismatch_o and saturates at 2^CNT_W−1 (no wrap).
- clear_i takes priority over an increment in the same cycle (result 0).
- FSM, evaluated on S3 results:
  - IDLE: first valid_o → TRACK; the match run counter loads 1 if matched, else 0.
  - TRACK: a match increments the run counter; when it reaches LOCK_COUNT → LOCKED. A mismatch resets the run counter to 0 and the state stays TRACK.
  - LOCKED: a mismatch → FAULT. Matches keep LOCKED.
  - FAULT: sticky; left only by clear_i or reset.
  - clear_i from any state → IDLE next cycle. It does not flush the pipeline or the delay line.
- Reset mid-stream flushes everything. The first valid_o after reset is ≥3 cycles after the first valid_i. The reference line refills from 0, so the first REF_DELAY+3 cycles compare against zeros; integrators gate valid_i accordingly.

Optional Feature:
- Macro: DEM_RECOMB_RANGE_CHECK_EN.
- When defined:
  - Adds output range_err_o (1 bit, reset 0), registered in S3 with valid_o.
  - range_err_o=1 when valid_o and x_sum_o lies outside the signed IN_W range [−2^(IN_W−1), 2^(IN_W−1)−1].
  - A range error also counts as a mismatch for the FSM and for the counter.
- When not defined: port and logic are absent, and range is never checked.

Test Plan:
- Exact split (IN_W=8): x_ref_i=8, then 3 cycles later all leaves=1 with valid_i. Expect x_sum_o=8, match_o=1, mismatch_o=0, with valid_o exactly 3 cycles after valid_i.
- Signed sum: leaves {−4,−4,−4,−4,−4,−4,−4,−4}, ref=−32. Expect x_sum_o=−32 (11-bit 0x7E0), match_o=1.
- Lock then fault: 4 consecutive valid matches → state_o goes 01→10 on the 4th. A single leaf corrupted by +1 → mismatch_o pulse, state_o=11, mismatch_cnt_o=1. clear_i → state_o=00, count 0.
- Saturation (CNT_W=2): 5 consecutive mismatches → counter goes 1,2,3,3,3. clear_i together with a mismatch → counter 0.
- Async reset: assert reset_i low mid-pipeline, between clock edges. All outputs go 0 immediately. After release, the first valid_o appears 3 cycles after the next valid_i.
- With DEM_RECOMB_RANGE_CHECK_EN (IN_W=8): all leaves=+20, ref=+127. Sum=160 → range_err_o=1, mismatch_o=1, state LOCKED→FAULT.

Source files
------------

// File: rtl/dem_tree_recombiner.sv
// Receive-side recombiner for the 3-layer DEM switching tree: sums the 8 leaf codes
// and checks them against the delayed tree input. Optional range check: DEM_RECOMB_RANGE_CHECK_EN.

package lib_switchblock_pkg;
  parameter int INPUT_WIDTH = 8;
endpackage

// state  | meaning
// IDLE   | no valid result seen since reset/clear
// TRACK  | results arriving, counting consecutive matches
// LOCKED | LOCK_COUNT consecutive matches seen, watching for a mismatch
// FAULT  | mismatch seen while locked; held until clear or reset
module dem_tree_recombiner #(
  parameter int IN_W       = lib_switchblock_pkg::INPUT_WIDTH,
  parameter int REF_DELAY  = 3,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [7:0][IN_W-1:0]       x_leaf_i,
  input  logic [IN_W-1:0]            x_ref_i,
  input  logic                       clear_i,
  output logic signed [IN_W+2:0]     x_sum_o,
  output logic                       valid_o,
  output logic                       match_o,
  output logic                       mismatch_o,
  output logic [CNT_W-1:0]           mismatch_cnt_o,
  output logic [1:0]                 state_o
`ifdef DEM_RECOMB_RANGE_CHECK_EN
  ,
  output logic                       range_err_o
`endif
);

  // The S3 result register is the last cycle of the REF_DELAY+3 reference delay.
  localparam int REF_LEN = REF_DELAY + 2;
  localparam int RUN_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10,
    FAULT  = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;

  logic signed [IN_W:0]   s1_q [4];
  logic signed [IN_W+1:0] s2_q [2];
  logic                   s1_valid_q, s2_valid_q;
  logic [IN_W-1:0]        ref_q [REF_LEN];

  logic signed [IN_W+2:0] sum3_d, ref_ext;
  logic                   eq_d, range_d, mis_d, good_d;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 4; i++) s1_q[i] <= '0;
      for (int i = 0; i < 2; i++) s2_q[i] <= '0;
      for (int i = 0; i < REF_LEN; i++) ref_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        s1_q[i] <= $signed({x_leaf_i[2*i][IN_W-1], x_leaf_i[2*i]})
                 + $signed({x_leaf_i[2*i+1][IN_W-1], x_leaf_i[2*i+1]});
      for (int i = 0; i < 2; i++)
        s2_q[i] <= $signed({s1_q[2*i][IN_W], s1_q[2*i]})
                 + $signed({s1_q[2*i+1][IN_W], s1_q[2*i+1]});
      s1_valid_q <= valid_i;
      s2_valid_q <= s1_valid_q;
      ref_q[0] <= x_ref_i;
      for (int i = 1; i < REF_LEN; i++) ref_q[i] <= ref_q[i-1];
    end
  end

  always_comb begin
    sum3_d  = $signed({s2_q[0][IN_W+1], s2_q[0]}) + $signed({s2_q[1][IN_W+1], s2_q[1]});
    ref_ext = $signed({{3{ref_q[REF_LEN-1][IN_W-1]}}, ref_q[REF_LEN-1]});
    eq_d    = (sum3_d == ref_ext);
`ifdef DEM_RECOMB_RANGE_CHECK_EN
    // In range only when the top four bits are a pure sign extension.
    range_d = !((&sum3_d[IN_W+2:IN_W-1]) || ~(|sum3_d[IN_W+2:IN_W-1]));
`else
    range_d = 1'b0;
`endif
    mis_d   = s2_valid_q & (~eq_d | range_d);
    good_d  = ~mis_d;
    run_inc = run_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        if (s2_valid_q) begin
          state_d = TRACK;
          run_d   = good_d ? RUN_W'(1) : '0;
        end
      end
      TRACK: begin
        if (s2_valid_q) begin
          if (good_d) begin
            run_d = run_inc;
            if (run_inc >= RUN_TGT) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
      end
      LOCKED: begin
        if (mis_d) state_d = FAULT;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      run_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= IDLE;
      run_q          <= '0;
      x_sum_o        <= '0;
      valid_o        <= 1'b0;
      match_o        <= 1'b0;
      mismatch_o     <= 1'b0;
      mismatch_cnt_o <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      valid_o    <= s2_valid_q;
      match_o    <= s2_valid_q & eq_d;
      mismatch_o <= mis_d;
      if (s2_valid_q) x_sum_o <= sum3_d;
      if (clear_i)
        mismatch_cnt_o <= '0;
      else if (mis_d && (mismatch_cnt_o != {CNT_W{1'b1}}))
        mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
    end
  end

`ifdef DEM_RECOMB_RANGE_CHECK_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) range_err_o <= 1'b0;
    else          range_err_o <= s2_valid_q & range_d;
  end
`endif

  assign state_o = state_q;

endmodule
